// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// if_fetch_ctrl : instruction-fetch sequencer with prefetch FIFO for decode.
// Optional perf counters when IF_FETCH_PERF_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [1:0]  state
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      last_instr_q, last_instr_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [31:0]      buf_instr_d [BUF_DEPTH];
  logic [31:0]      buf_pc_q    [BUF_DEPTH];
  logic [31:0]      buf_pc_d    [BUF_DEPTH];

  logic pop;
  logic push;
  logic stall_full;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  assign push       = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | pop);
  assign stall_full = fetch_en & ~redirect_valid & ~push;

  assign imem_addr = fetch_pc_q;
  assign state     = state_q;
  // Empty FIFO shows the last entry handed to decode rather than stale storage.
  assign out_instr = out_valid ? buf_instr_q[rd_ptr_q] : last_instr_q;
  assign out_pc    = out_valid ? buf_pc_q[rd_ptr_q]    : last_pc_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    state_d      = state_q;

    if (pop) begin
      last_instr_d = buf_instr_q[rd_ptr_q];
      last_pc_d    = buf_pc_q[rd_ptr_q];
    end

    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        buf_instr_d[wr_ptr_q] = imem_rdata;
        buf_pc_d[wr_ptr_q]    = fetch_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    if (!fetch_en) begin
      state_d = ST_IDLE;
    end else if (push) begin
      state_d = ST_RUN;
    end else begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_instr_q <= '0;
      last_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
    end
  end

  // Storage is only read while count_q != 0, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + (push ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q + (stall_full ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  logic unused_stall_full;
  assign unused_stall_full = stall_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
// tb_if_fetch_ctrl : directed self-checking bench for if_fetch_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic        out_valid;
  logic [1:0]  state;

  logic [31:0] w_imem_addr, w_imem_rdata, w_out_instr, w_out_pc;
  logic        w_out_valid;
  logic [1:0]  w_state;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  int checks;
  int failures;

  assign imem_rdata   = 32'hA000_0000 | imem_addr;
  assign w_imem_rdata = 32'hA000_0000 | w_imem_addr;

  if_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef IF_FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .state          (state)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (w_imem_addr),
    .imem_rdata     (w_imem_rdata),
    .out_valid      (w_out_valid),
    .out_ready      (out_ready),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc),
`ifdef IF_FETCH_PERF_CNT_EN
    .perf_fetched   (w_perf_fetched),
    .perf_stall     (w_perf_stall),
`endif
    .state          (w_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // Reset state
    step();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_state", {30'b0, state}, 32'h0);
    chk("rst_waddr", w_imem_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    // Streaming with out_ready high, plus PC wrap on the second instance
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("s1_valid", {31'b0, out_valid}, 32'h1);
    chk("s1_pc",    out_pc, 32'h0);
    chk("s1_instr", out_instr, 32'hA000_0000);
    chk("s1_state", {30'b0, state}, 32'h1);
    chk("w1_pc",    w_out_pc, 32'hFFFF_FFF8);
    step();
    chk("s2_pc",    out_pc, 32'h4);
    chk("s2_instr", out_instr, 32'hA000_0004);
    chk("w2_pc",    w_out_pc, 32'hFFFF_FFFC);
    step();
    chk("s3_pc",    out_pc, 32'h8);
    chk("w3_pc",    w_out_pc, 32'h0);
    chk("w3_instr", w_out_instr, 32'hA000_0000);
    step();
    chk("s4_pc",    out_pc, 32'hC);
    chk("s4_instr", out_instr, 32'hA000_000C);

    // Backpressure: fill two entries, then drain without gap
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_pc",    out_pc, 32'h0);
    chk("bp_addr",  imem_addr, 32'h8);
    chk("bp_state", {30'b0, state}, 32'h2);
    out_ready = 1'b1;
    step();
    chk("dr1_pc",    out_pc, 32'h4);
    chk("dr1_state", {30'b0, state}, 32'h1);
    step();
    chk("dr2_pc",    out_pc, 32'h8);
    chk("dr2_instr", out_instr, 32'hA000_0008);

    // Redirect with two entries buffered, same cycle as fetch_en
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    chk("rd_valid", {31'b0, out_valid}, 32'h0);
    chk("rd_addr",  imem_addr, 32'h100);
    chk("rd_state", {30'b0, state}, 32'h2);
    chk("rd_hold",  out_pc, 32'h4);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step();
    chk("rt1_valid", {31'b0, out_valid}, 32'h1);
    chk("rt1_pc",    out_pc, 32'h100);
    chk("rt1_instr", out_instr, 32'hA000_0100);
    step();
    chk("rt2_pc",    out_pc, 32'h104);

    // Asynchronous reset mid-stream with two entries buffered
    out_ready = 1'b0;
    step();
    step();
    chk("pre_valid", {31'b0, out_valid}, 32'h1);
    chk("pre_addr",  imem_addr, 32'h10C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_addr",  imem_addr, 32'h0);
    chk("ar_pc",    out_pc, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("ar_pfetch", perf_fetched, 32'h0);
    chk("ar_pstall", perf_stall, 32'h0);
`endif
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rs_pc",   out_pc, 32'h0);
    chk("rs_addr", imem_addr, 32'h4);

    // fetch_en drop with one entry buffered: it drains, PC freezes
    fetch_en = 1'b0;
    step();
    chk("fd_valid", {31'b0, out_valid}, 32'h0);
    chk("fd_addr",  imem_addr, 32'h4);
    chk("fd_state", {30'b0, state}, 32'h0);
    chk("fd_pc",    out_pc, 32'h0);
    step();
    chk("fd2_addr",  imem_addr, 32'h4);
    chk("fd2_valid", {31'b0, out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
